uart_core_cfg: RTL

Parametrised successor to the fixed 8N1 UART TX/RX pair. It provides a full-duplex UART with compile-time frame format (data bits, parity, stop bits) and a runtime baud divisor. It adds valid/ready handshakes, a one-entry RX holding register with overrun detection, and an internal loopback mode. It sits between the peripheral register block and the pad-level serial pins.

---
 rtl/uart_cfg_pkg.sv | 34 +++
 rtl/uart_cfg_rx.sv | 124 ++++++++++++
 rtl/uart_cfg_tx.sv | 118 +++++++++++
 rtl/uart_core_cfg.sv | 109 ++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_pkg
// Description : Shared state encodings, constants and parity helper for the
//               configurable UART core.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cfg_pkg;

    localparam int MIN_DIV = 4;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cfg_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_rx
// Description : UART receiver with 2-flop synchroniser, mid-bit sampling and
//               false-start rejection; emits a one-cycle strobe per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_rx
    import uart_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     i_div,
    input  logic                 i_line,
    output logic                 o_done,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_perr,
    output logic                 o_ferr
);

    localparam int            BW         = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          c_ODD      = (PARITY_ODD != 0);

    rx_state_t            r_state, w_state_next;
    logic [DIV_W-1:0]     r_div, r_cnt, w_div;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_s1, r_s2, r_s3;
    logic                 w_line, w_fall, w_start, w_bit_end;

    assign w_div  = (i_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div;
    assign w_line = r_s2;
    assign w_fall = r_s3 & ~r_s2;
    assign o_data = r_shift;
    assign o_perr = r_perr;
    assign o_ferr = ~w_line;

    // r_s3 only remembers the previous synchronised level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_line;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_bit_end    = (r_cnt == DIV_W'(1));
        o_done       = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_start      = 1'b1;
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (w_bit_end) w_state_next = w_line ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_bit_end && (r_bit == c_LAST_BIT))
                    w_state_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (w_bit_end) w_state_next = RX_STOP;
            end
            RX_STOP: begin
                if (w_bit_end) begin
                    o_done       = 1'b1;
                    w_state_next = RX_IDLE;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // First wait is half a bit so every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= DIV_W'(MIN_DIV);
            r_cnt   <= DIV_W'(MIN_DIV);
            r_bit   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
        end else if (w_start) begin
            r_div  <= w_div;
            r_cnt  <= w_div >> 1;
            r_bit  <= '0;
            r_perr <= 1'b0;
        end else if (r_state != RX_IDLE) begin
            if (w_bit_end) begin
                r_cnt <= r_div;
                if (r_state == RX_DATA) begin
                    r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
                    r_bit   <= r_bit + 1'b1;
                end
                if (r_state == RX_PARITY)
                    r_perr <= parity_of(8'(r_shift), c_ODD) ^ w_line;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cfg_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_tx
// Description : UART transmitter with compile-time frame format and a baud
//               divisor latched at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_tx
    import uart_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     i_div,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_line,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int              BW          = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0]   c_LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic            c_STOP_MORE = (STOP_BITS == 2);
    localparam logic            c_ODD       = (PARITY_ODD != 0);

    tx_state_t            r_state, w_state_next;
    logic [DIV_W-1:0]     r_div, r_cnt, w_div;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_stop_left;
    logic                 w_start, w_bit_end;

    assign w_div = (i_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div;

    always_ff @(posedge clk) begin
        if (rst) r_state <= TX_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_bit_end    = (r_cnt == DIV_W'(1));
        o_line       = 1'b1;
        o_ready      = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    w_start      = 1'b1;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                o_line = 1'b0;
                if (w_bit_end) w_state_next = TX_DATA;
            end
            TX_DATA: begin
                o_line = r_shift[0];
                if (w_bit_end && (r_bit == c_LAST_BIT))
                    w_state_next = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                o_line = r_par;
                if (w_bit_end) w_state_next = TX_STOP;
            end
            TX_STOP: begin
                if (w_bit_end && !r_stop_left) begin
                    o_done       = 1'b1;
                    w_state_next = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    // Parity is taken from the latched word so the shifter can consume it freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= DIV_W'(MIN_DIV);
            r_cnt       <= DIV_W'(MIN_DIV);
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_stop_left <= 1'b0;
        end else if (w_start) begin
            r_div       <= w_div;
            r_cnt       <= w_div;
            r_bit       <= '0;
            r_shift     <= i_data;
            r_par       <= parity_of(8'(i_data), c_ODD);
            r_stop_left <= c_STOP_MORE;
        end else if (r_state != TX_IDLE) begin
            if (w_bit_end) begin
                r_cnt <= r_div;
                if (r_state == TX_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 1'b1;
                end
                if (r_state == TX_STOP) r_stop_left <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_core_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_cfg
// Description : Full-duplex configurable UART: TX/RX engines, loopback mux and
//               a one-entry RX holding register with overrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core_cfg
    import uart_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 loopback,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx_serial,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 rx_overrun
);

    logic                 w_tx_line, w_rx_in;
    logic                 w_rx_done, w_rx_perr, w_rx_ferr, w_load;
    logic [DATA_BITS-1:0] w_rx_word;
    logic                 r_valid, r_perr, r_ferr, r_overrun;
    logic [DATA_BITS-1:0] r_data;

    assign tx_serial = loopback ? 1'b1 : w_tx_line;
    assign w_rx_in   = loopback ? w_tx_line : rx_serial;

    uart_cfg_tx #(
        .DATA_BITS  (DATA_BITS),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .STOP_BITS  (STOP_BITS),
        .DIV_W      (DIV_W)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_div   (baud_div),
        .i_valid (tx_valid),
        .o_ready (tx_ready),
        .i_data  (tx_data),
        .o_line  (w_tx_line),
        .o_busy  (tx_busy),
        .o_done  (tx_done)
    );

    uart_cfg_rx #(
        .DATA_BITS  (DATA_BITS),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .DIV_W      (DIV_W)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .i_div  (baud_div),
        .i_line (w_rx_in),
        .o_done (w_rx_done),
        .o_data (w_rx_word),
        .o_perr (w_rx_perr),
        .o_ferr (w_rx_ferr)
    );

    // A read in the same cycle frees the slot, so a new frame may replace it.
    assign w_load = w_rx_done && (!r_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_rx_done && r_valid && !rx_ready;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_rx_word;
                r_perr  <= w_rx_perr;
                r_ferr  <= w_rx_ferr;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_valid     = r_valid;
    assign rx_data      = r_data;
    assign parity_error = r_perr;
    assign frame_error  = r_ferr;
    assign rx_overrun   = r_overrun;

endmodule
`default_nettype wire
